// File: rtl/hazard_fwd_scoreboard.sv
// hazard_fwd_scoreboard: data-hazard unit for the pipelined RISC-V core.
// Keeps a shadow pipeline of destination tags from EX (entry 0) through the
// last forwarding stage (entry FWD_STAGES). It produces registered-only
// forwarding selects for the EX operands and a combinational load-use stall
// for the instruction in ID.
// Optional feature: define FWD_PERF_CNT_EN to add the 16-bit saturating
// stall_cnt port counting load-use stall cycles.
module hazard_fwd_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int NUM_RD     = 2,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_READY = 2,
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       freeze,
    input  logic                       flush,
    input  logic                       id_valid,
    input  logic                       id_we,
    input  logic                       id_load,
    input  logic [REG_AW-1:0]          id_rd,
    input  logic [NUM_RD*REG_AW-1:0]   id_rs,
    output logic                       stall,
    output logic [NUM_RD*SEL_W-1:0]    ex_fwd_sel
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [15:0]                stall_cnt
`endif
);

    typedef struct packed {
        logic              valid;
        logic              we;
        logic              load;
        logic [REG_AW-1:0] rd;
    } entry_t;

    entry_t            ent   [0:FWD_STAGES];
    logic [REG_AW-1:0] ex_rs [NUM_RD];
    logic              hazard;

    // A stage produces a register value only if it is real, writes, and
    // does not target x0.
    function automatic logic is_producer(input entry_t e);
        return e.valid && e.we && (e.rd != '0);
    endfunction

    // Forwarding selects: youngest matching producer among entries 1..N,
    // computed from registered state only.
    always_comb begin
        logic [SEL_W-1:0] sel_v;
        logic             found;
        ex_fwd_sel = '0;
        sel_v      = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            sel_v = '0;
            found = 1'b0;
            if (ent[0].valid) begin
                for (int unsigned k = 1; k <= FWD_STAGES; k++) begin
                    if (!found && is_producer(ent[k]) && (ent[k].rd == ex_rs[i])) begin
                        sel_v = SEL_W'(k);
                        found = 1'b1;
                    end
                end
            end
            ex_fwd_sel[i*SEL_W +: SEL_W] = sel_v;
        end
    end

    // Load-use hazard: an ID source matches a load whose data is not yet
    // forwardable by the time the reader would reach EX.
    always_comb begin
        logic [REG_AW-1:0] rs;
        hazard = 1'b0;
        rs     = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rs = id_rs[i*REG_AW +: REG_AW];
            for (int unsigned j = 0; j < FWD_STAGES; j++) begin
                if (((j + 1) < unsigned'(LOAD_READY)) && (rs != '0) &&
                    is_producer(ent[j]) && ent[j].load && (ent[j].rd == rs)) begin
                    hazard = 1'b1;
                end
            end
        end
        stall = id_valid && !flush && hazard;
    end

    // Shadow pipeline advance: hold on freeze, otherwise shift and load
    // entry 0 with the ID instruction or a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k <= FWD_STAGES; k++) begin
                ent[k] <= '0;
            end
            for (int unsigned i = 0; i < NUM_RD; i++) begin
                ex_rs[i] <= '0;
            end
        end else if (!freeze) begin
            for (int unsigned k = 1; k <= FWD_STAGES; k++) begin
                ent[k] <= ent[k-1];
            end
            if (flush || stall) begin
                ent[0] <= '0;
                for (int unsigned i = 0; i < NUM_RD; i++) begin
                    ex_rs[i] <= '0;
                end
            end else begin
                ent[0].valid <= id_valid;
                ent[0].we    <= id_we;
                ent[0].load  <= id_load;
                ent[0].rd    <= id_rd;
                for (int unsigned i = 0; i < NUM_RD; i++) begin
                    ex_rs[i] <= id_rs[i*REG_AW +: REG_AW];
                end
            end
        end
    end

`ifdef FWD_PERF_CNT_EN
    // Saturating count of cycles in which a load-use stall takes effect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stall && !freeze && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Directed bench for hazard_fwd_scoreboard. Three instances share the ID
// inputs: default parameters (a), FWD_STAGES=3/LOAD_READY=3 (b) and
// LOAD_READY=1 (c).
module tb_hazard_fwd_scoreboard;

    logic       clk;
    logic       reset_n;
    logic       freeze;
    logic       flush;
    logic       id_valid;
    logic       id_we;
    logic       id_load;
    logic [4:0] id_rd;
    logic [9:0] id_rs;

    logic       stall_a, stall_b, stall_c;
    logic [3:0] sel_a, sel_b, sel_c;
`ifdef FWD_PERF_CNT_EN
    logic [15:0] cnt_a, cnt_b, cnt_c;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    hazard_fwd_scoreboard #(.REG_AW(5), .NUM_RD(2), .FWD_STAGES(2), .LOAD_READY(2)) u_a (
        .clk(clk), .reset_n(reset_n), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_we(id_we), .id_load(id_load), .id_rd(id_rd), .id_rs(id_rs),
        .stall(stall_a), .ex_fwd_sel(sel_a)
`ifdef FWD_PERF_CNT_EN
        , .stall_cnt(cnt_a)
`endif
    );

    hazard_fwd_scoreboard #(.REG_AW(5), .NUM_RD(2), .FWD_STAGES(3), .LOAD_READY(3)) u_b (
        .clk(clk), .reset_n(reset_n), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_we(id_we), .id_load(id_load), .id_rd(id_rd), .id_rs(id_rs),
        .stall(stall_b), .ex_fwd_sel(sel_b)
`ifdef FWD_PERF_CNT_EN
        , .stall_cnt(cnt_b)
`endif
    );

    hazard_fwd_scoreboard #(.REG_AW(5), .NUM_RD(2), .FWD_STAGES(2), .LOAD_READY(1)) u_c (
        .clk(clk), .reset_n(reset_n), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_we(id_we), .id_load(id_load), .id_rd(id_rd), .id_rs(id_rs),
        .stall(stall_c), .ex_fwd_sel(sel_c)
`ifdef FWD_PERF_CNT_EN
        , .stall_cnt(cnt_c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic we, input logic ld,
                         input logic [4:0] rd, input logic [4:0] rs0, input logic [4:0] rs1);
        id_valid = v;
        id_we    = we;
        id_load  = ld;
        id_rd    = rd;
        id_rs    = {rs1, rs0};
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        freeze  = 1'b0;
        flush   = 1'b0;
        idle();
        #2;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        freeze  = 1'b0;
        flush   = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 5'd3);
        #1;
        n_cmp++; if (stall_a !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", stall_a); end
        n_cmp++; if (sel_a !== 4'h0) begin n_bad++; $display("FAIL reset_sel got=%h exp=0", sel_a); end
`ifdef FWD_PERF_CNT_EN
        n_cmp++; if (cnt_a !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt_a); end
`endif
        apply_reset();
    endtask

    task automatic test_alu_chain();
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd1, 5'd2);          // add x5,x1,x2
        #1;
        n_cmp++; if (stall_a !== 1'b0) begin n_bad++; $display("FAIL chain_stall0 got=%b exp=0", stall_a); end
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd5);          // sub x6,x5,x5
        #1;
        n_cmp++; if (stall_a !== 1'b0) begin n_bad++; $display("FAIL chain_stall1 got=%b exp=0", stall_a); end
        n_cmp++; if (sel_a !== 4'h0) begin n_bad++; $display("FAIL chain_sel_add got=%h exp=0", sel_a); end
        tick();
        idle();
        #1;
        n_cmp++; if (sel_a !== 4'b0101) begin n_bad++; $display("FAIL chain_sel got=%b exp=0101", sel_a); end
    endtask

    task automatic test_younger_wins();
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd1, 5'd2); tick();  // add x5
        drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd3, 5'd4); tick();  // add x5
        drive(1'b1, 1'b1, 1'b0, 5'd7, 5'd5, 5'd0); tick();  // or x7,x5,x0
        idle();
        #1;
        n_cmp++; if (sel_a !== 4'b0001) begin n_bad++; $display("FAIL younger_sel got=%b exp=0001", sel_a); end
        // Producer two stages back with a bubble in between selects stage 2.
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd1, 5'd2); tick();
        idle(); tick();
        drive(1'b1, 1'b1, 1'b0, 5'd7, 5'd5, 5'd5); tick();
        idle();
        #1;
        n_cmp++; if (sel_a !== 4'b1010) begin n_bad++; $display("FAIL stage2_sel got=%b exp=1010", sel_a); end
    endtask

    task automatic test_load_use();
        apply_reset();
        drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd2, 5'd0);          // lw x3,0(x2)
        #1;
        n_cmp++; if (stall_a !== 1'b0) begin n_bad++; $display("FAIL lu_stall_pre got=%b exp=0", stall_a); end
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd4, 5'd3, 5'd1);          // add x4,x3,x1
        #1;
        n_cmp++; if (stall_a !== 1'b1) begin n_bad++; $display("FAIL lu_stall got=%b exp=1", stall_a); end
        n_cmp++; if (stall_c !== 1'b0) begin n_bad++; $display("FAIL lr1_stall got=%b exp=0", stall_c); end
        tick();
        n_cmp++; if (stall_a !== 1'b0) begin n_bad++; $display("FAIL lu_stall_end got=%b exp=0", stall_a); end
        n_cmp++; if (sel_a !== 4'h0) begin n_bad++; $display("FAIL lu_bubble_sel got=%b exp=0000", sel_a); end
        n_cmp++; if (sel_c !== 4'b0001) begin n_bad++; $display("FAIL lr1_sel got=%b exp=0001", sel_c); end
        tick();
        idle();
        #1;
        n_cmp++; if (sel_a !== 4'b0010) begin n_bad++; $display("FAIL lu_sel got=%b exp=0010", sel_a); end
        n_cmp++; if (stall_a !== 1'b0) begin n_bad++; $display("FAIL lu_stall_after got=%b exp=0", stall_a); end
`ifdef FWD_PERF_CNT_EN
        n_cmp++; if (cnt_a !== 16'd1) begin n_bad++; $display("FAIL lu_cnt got=%0d exp=1", cnt_a); end
        n_cmp++; if (cnt_c !== 16'd0) begin n_bad++; $display("FAIL lr1_cnt got=%0d exp=0", cnt_c); end
`endif
    endtask

    task automatic test_load_ready3();
        apply_reset();
        drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd2, 5'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd4, 5'd3, 5'd1);
        #1;
        n_cmp++; if (stall_b !== 1'b1) begin n_bad++; $display("FAIL lr3_stall0 got=%b exp=1", stall_b); end
        tick();
        n_cmp++; if (stall_b !== 1'b1) begin n_bad++; $display("FAIL lr3_stall1 got=%b exp=1", stall_b); end
        n_cmp++; if (sel_b !== 4'h0) begin n_bad++; $display("FAIL lr3_bubble_sel got=%b exp=0000", sel_b); end
        tick();
        n_cmp++; if (stall_b !== 1'b0) begin n_bad++; $display("FAIL lr3_stall2 got=%b exp=0", stall_b); end
        tick();
        idle();
        #1;
        n_cmp++; if (sel_b !== 4'b0011) begin n_bad++; $display("FAIL lr3_sel got=%b exp=0011", sel_b); end
`ifdef FWD_PERF_CNT_EN
        n_cmp++; if (cnt_b !== 16'd2) begin n_bad++; $display("FAIL lr3_cnt got=%0d exp=2", cnt_b); end
`endif
    endtask

    task automatic test_x0_nowrite();
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd1, 5'd0); tick();  // addi x0,x1,imm
        drive(1'b1, 1'b0, 1'b0, 5'd5, 5'd2, 5'd5); tick();  // sw (rd field 5, we=0)
        drive(1'b1, 1'b1, 1'b0, 5'd8, 5'd0, 5'd5);          // or x8,x0,x5
        #1;
        n_cmp++; if (stall_a !== 1'b0) begin n_bad++; $display("FAIL x0_stall0 got=%b exp=0", stall_a); end
        tick();
        idle();
        #1;
        n_cmp++; if (sel_a !== 4'h0) begin n_bad++; $display("FAIL x0_sel got=%b exp=0000", sel_a); end
        drive(1'b1, 1'b1, 1'b1, 5'd0, 5'd2, 5'd0); tick();  // lw x0
        drive(1'b1, 1'b1, 1'b0, 5'd9, 5'd0, 5'd0);
        #1;
        n_cmp++; if (stall_a !== 1'b0) begin n_bad++; $display("FAIL x0_load_stall got=%b exp=0", stall_a); end
        n_cmp++; if (stall_b !== 1'b0) begin n_bad++; $display("FAIL x0_load_stall_b got=%b exp=0", stall_b); end
        tick();
        drive(1'b1, 1'b0, 1'b1, 5'd3, 5'd2, 5'd0); tick();  // load with we=0
        drive(1'b1, 1'b1, 1'b0, 5'd9, 5'd3, 5'd3);
        #1;
        n_cmp++; if (stall_a !== 1'b0) begin n_bad++; $display("FAIL nowe_load_stall got=%b exp=0", stall_a); end
    endtask

    task automatic test_freeze();
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd1, 5'd2); tick();  // add x5
        drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd5, 5'd0); tick();  // lw x3,0(x5)
        drive(1'b1, 1'b1, 1'b0, 5'd4, 5'd3, 5'd5);          // add x4,x3,x5
        #1;
        n_cmp++; if (stall_a !== 1'b1) begin n_bad++; $display("FAIL frz_stall_pre got=%b exp=1", stall_a); end
        n_cmp++; if (sel_a !== 4'b0001) begin n_bad++; $display("FAIL frz_sel_pre got=%b exp=0001", sel_a); end
        freeze = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (stall_a !== 1'b1) begin n_bad++; $display("FAIL frz_stall[%0d] got=%b exp=1", c, stall_a); end
            n_cmp++; if (sel_a !== 4'b0001) begin n_bad++; $display("FAIL frz_sel[%0d] got=%b exp=0001", c, sel_a); end
`ifdef FWD_PERF_CNT_EN
            n_cmp++; if (cnt_a !== 16'd0) begin n_bad++; $display("FAIL frz_cnt[%0d] got=%0d exp=0", c, cnt_a); end
`endif
        end
        freeze = 1'b0;
        tick();
        n_cmp++; if (stall_a !== 1'b0) begin n_bad++; $display("FAIL frz_stall_post got=%b exp=0", stall_a); end
        n_cmp++; if (sel_a !== 4'h0) begin n_bad++; $display("FAIL frz_bubble_sel got=%b exp=0000", sel_a); end
        tick();
        idle();
        #1;
        n_cmp++; if (sel_a !== 4'b0010) begin n_bad++; $display("FAIL frz_sel_post got=%b exp=0010", sel_a); end
`ifdef FWD_PERF_CNT_EN
        n_cmp++; if (cnt_a !== 16'd1) begin n_bad++; $display("FAIL frz_cnt_post got=%0d exp=1", cnt_a); end
`endif
    endtask

    task automatic test_flush();
        apply_reset();
        drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd2, 5'd0); tick();
        drive(1'b1, 1'b1, 1'b0, 5'd4, 5'd3, 5'd1);
        flush = 1'b1;
        #1;
        n_cmp++; if (stall_a !== 1'b0) begin n_bad++; $display("FAIL flush_stall got=%b exp=0", stall_a); end
        tick();
        flush = 1'b0;
        #1;
        n_cmp++; if (stall_a !== 1'b0) begin n_bad++; $display("FAIL flush_stall_next got=%b exp=0", stall_a); end
        n_cmp++; if (sel_a !== 4'h0) begin n_bad++; $display("FAIL flush_bubble_sel got=%b exp=0000", sel_a); end
        tick();
        idle();
        #1;
        n_cmp++; if (sel_a !== 4'b0010) begin n_bad++; $display("FAIL flush_sel got=%b exp=0010", sel_a); end
`ifdef FWD_PERF_CNT_EN
        n_cmp++; if (cnt_a !== 16'd0) begin n_bad++; $display("FAIL flush_cnt got=%0d exp=0", cnt_a); end
`endif
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd1, 5'd2); tick();
        drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd5, 5'd0); tick();
        drive(1'b1, 1'b1, 1'b0, 5'd4, 5'd3, 5'd5);
        #1;
        n_cmp++; if (stall_a !== 1'b1) begin n_bad++; $display("FAIL rstmid_stall_pre got=%b exp=1", stall_a); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (stall_a !== 1'b0) begin n_bad++; $display("FAIL rstmid_stall got=%b exp=0", stall_a); end
        n_cmp++; if (sel_a !== 4'h0) begin n_bad++; $display("FAIL rstmid_sel got=%b exp=0000", sel_a); end
        n_cmp++; if (stall_b !== 1'b0) begin n_bad++; $display("FAIL rstmid_stall_b got=%b exp=0", stall_b); end
`ifdef FWD_PERF_CNT_EN
        n_cmp++; if (cnt_b !== 16'd0) begin n_bad++; $display("FAIL rstmid_cnt_b got=%0d exp=0", cnt_b); end
`endif
        #1;
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_younger_wins();
        test_load_use();
        test_load_ready3();
        test_x0_nowrite();
        test_freeze();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_scoreboard.md
# hazard_fwd_scoreboard

Parametrised data-hazard unit for the pipelined RISC-V core. It replaces the purely combinational forwarding unit. The block keeps its own shadow pipeline of destination-register tags from EX through the last forwarding stage. From these tags it produces per-operand forwarding selects for the instruction in EX and a load-use stall for the instruction in ID. It sits beside the decode/execute boundary and drives the operand muxes and the IF/ID hold logic.

## Interface
- `REG_AW`, 5: register address width.
- `NUM_RD`, 2: source operands per instruction.
- `FWD_STAGES`, 2: forwarding stages after EX (1 = MEM, 2 = WB, …); range 1–6.
- `LOAD_READY`, 2: first stage index at which load data can be forwarded; range 1 to `FWD_STAGES`.
- `SEL_W`, derived, $clog2(FWD_STAGES+1): select width.

Ports:
- `clk`  in  1  core clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `freeze`  in  1  global pipeline hold (e.g. memory wait).
- `flush`  in  1  squash the ID instruction (taken branch/jump).
- `id_valid`  in  1  ID holds a real instruction.
- `id_we`  in  1  ID instruction writes a register.
- `id_load`  in  1  ID instruction is a load.
- `id_rd`  in  `REG_AW`  ID destination register.
- `id_rs`  in  `NUM_RD*REG_AW`  ID source registers; operand i is at bits [i*REG_AW +: REG_AW].
- `stall`  out  1  hold PC and IF/ID, insert a bubble into EX.
- `ex_fwd_sel`  out  `NUM_RD*SEL_W`  per EX operand: 0 = register file, k = stage k.
- `stall_cnt`  out  16  load-use stall cycles; only present with `FWD_PERF_CNT_EN`.

## Operation
- Internal entries are numbered 0..`FWD_STAGES`; entry 0 is EX.
- Each entry holds {valid, we, load, rd}. Entry 0 additionally holds the `NUM_RD` rs tags.
- An entry is a producer only if valid=1, we=1 and rd≠0. Register x0 never matches and never stalls.
- Forwarding for EX operand i:
  - Select the smallest k in 1..`FWD_STAGES` whose entry k is a producer with rd equal to rs_i.
  - An EX entry that is invalid or a bubble gives select 0.
  - If no producer matches, the select is 0.
  - The younger stage always wins over older stages.
- Load-use stall:
  - `stall` = `id_valid` & !`flush` & (some operand id_rs_i≠0 matches a producer load in entry j with j+1 < `LOAD_READY`), for j in 0..`FWD_STAGES`-1.
  - With the default parameters, this is the classic one-cycle stall when a load sits in EX.
  - With `LOAD_READY`=1, no stall is ever raised.
- Advance, evaluated every rising clock edge:
  - `freeze`=1: all entries hold. `flush` and `stall` have no state effect; the controller must hold `flush` asserted until `freeze` drops.
  - Otherwise entry k ← entry k-1 for k≥1. Entry `FWD_STAGES`'s old content is dropped.
  - Entry 0 ← bubble (valid=0) if `flush` or `stall`; otherwise entry 0 ← ID fields.
- `ex_fwd_sel` is a function of registered entries only: glitch-free and independent of ID inputs.
- `stall` is combinational from ID inputs and entries.

## Timing
- Reset (async on `reset_n` low): all valid=0, `ex_fwd_sel`=0, `stall`=0, `stall_cnt`=0. Reset mid-stall clears the stall in the same cycle.
- Latency: an instruction accepted at edge t is in entry 0 during cycle t+1 and in entry k during cycle t+1+k, absent freeze.
- A load-use stall lasts exactly `LOAD_READY`-1 consecutive cycles, then deasserts without any external action.
- `stall` is asserted in the same cycle as the hazard condition.
- Flush and stall in the same cycle: flush wins, `stall`=0, and a bubble is inserted.
- While `freeze`=1 the outputs remain constant, because the entries hold.

## Configuration
- `FWD_PERF_CNT_EN` defined:
  - `stall_cnt` increments by one on each edge where `stall`=1 and `freeze`=0.
  - It saturates at 16'hFFFF.
  - Reset value is 0.
- `FWD_PERF_CNT_EN` not defined: the port and counter are absent, and the forwarding and stall behaviour is identical.

## Test plan
- ALU chain: `add x5` then `sub x6,x5,x5` back-to-back -> in cycle 2, `ex_fwd_sel` = {1,1} and `stall`=0.
- Two-apart with younger-wins priority:
  - `add x5` then `add x5` then `or x7,x5,x0` -> operand 0 selects 1, not 2.
  - Operand 1 (x0) selects 0.
- Load-use (defaults): `lw x3` followed by `add x4,x3,x1` -> `stall`=1 for exactly one cycle and a bubble in EX. Then `ex_fwd_sel` operand 0 = 2 and `stall_cnt`=1.
- `LOAD_READY`=3, `FWD_STAGES`=3: same load-use pair -> `stall` high for two cycles, then select 3.
- Writes to x0 and we=0 producers: `addi x0` and `sw` ahead of readers of x0 and rs -> all selects 0, no stall.
- Freeze and flush:
  - `freeze` is held for 3 cycles during a pending load-use -> `stall_cnt` unchanged, `ex_fwd_sel` constant.
  - `flush` together with a hazard -> `stall`=0 and a bubble is inserted.
  - `reset_n` pulsed low mid-sequence -> all outputs 0 immediately.
